control: RTL and testbench

Mealy/Moore control FSM for the shift-and-add multiplier. It sequences the datapath through load, conditional add, and shift steps. Inputs are start (`St`), current multiplier LSB (`M`) and last-bit flag (`K`). Outputs are one-cycle strobes consumed by the product register and the bit counter.

---
 rtl/control.sv | 155 +++++++++++++++
 tb/tb_control.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/control.sv
// -----------------------------------------------------------------------------
// control -- sequencing FSM for a shift-and-add multiplier.
//
// The controller walks the datapath through one load step, then through each
// multiplier bit. A bit of 1 costs an add cycle followed by a shift cycle. A
// bit of 0 costs a single shift cycle. After the last shift it raises a
// one-cycle done, then returns to idle.
//
// State encoding is fixed (2-bit binary):
//   S0 = 00  idle, waiting for St
//   S1 = 01  test multiplier LSB: add (M=1) or shift (M=0)
//   S2 = 10  shift that follows an add
//   S3 = 11  done
//
// Ports:
//   Clk   in   system clock, all state changes on the rising edge
//   Rst   in   synchronous active-high reset, forces S0
//   St    in   start request (looked at only in S0)
//   M     in   current multiplier bit (LSB of the product register)
//   K     in   bit-counter terminal flag, looked at only while Sh=1
//   Load  out  Mealy: load operands, clear the accumulator (S0 and St)
//   Ad    out  Mealy: add the multiplicand into the accumulator (S1 and M)
//   Sh    out  Mealy: shift the product right, advance the counter
//   Done  out  Moore: multiplication complete (S3)
//   Idle  out  Moore: controller is waiting for St (S0)
//   State out  2-bit registered state, present only when CONTROL_DBG_STATE_EN
//              is defined
//
// Build option:
//   CONTROL_DBG_STATE_EN -- when defined, adds the debug output State.
//                           Behaviour is otherwise the same.
// -----------------------------------------------------------------------------
module control (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       St,
  input  logic       M,
  input  logic       K,
  output logic       Load,
  output logic       Ad,
  output logic       Sh,
  output logic       Done,
  output logic       Idle
`ifdef CONTROL_DBG_STATE_EN
  ,
  output logic [1:0] State
`endif
);

  typedef enum logic [1:0] {
    S0_IDLE  = 2'b00,
    S1_TEST  = 2'b01,
    S2_SHIFT = 2'b10,
    S3_DONE  = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;

  // ---------------------------------------------------------------------------
  // State register. Reset is synchronous and takes priority over every input,
  // including an operation that is still in progress.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values. Combinational blocks below use blocking (=).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S0_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of the block means every path
  // drives state_nxt. Without it, a missed branch would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S0_IDLE: begin
        if (St) begin
          state_nxt = S1_TEST;
        end
      end
      S1_TEST: begin
        // M=1 always goes through the add/shift pair, so K is not looked at
        // until the shift cycle in S2.
        if (M) begin
          state_nxt = S2_SHIFT;
        end else if (K) begin
          state_nxt = S3_DONE;
        end
      end
      S2_SHIFT: begin
        state_nxt = K ? S3_DONE : S1_TEST;
      end
      S3_DONE: begin
        // St is ignored here. A held St restarts from S0 on the next cycle.
        state_nxt = S0_IDLE;
      end
      default: begin
        state_nxt = S0_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Load/Ad/Sh depend on the current inputs (Mealy).
  // Idle/Done depend only on the state (Moore). Only one strobe per state can
  // be raised, so Load/Ad/Sh/Done are mutually exclusive by construction.
  // ---------------------------------------------------------------------------
  always_comb begin
    Load = 1'b0;
    Ad   = 1'b0;
    Sh   = 1'b0;
    Done = 1'b0;
    Idle = 1'b0;
    case (state)
      S0_IDLE: begin
        Idle = 1'b1;
        Load = St;
      end
      S1_TEST: begin
        Ad = M;
        Sh = ~M;
      end
      S2_SHIFT: begin
        Sh = 1'b1;
      end
      S3_DONE: begin
        Done = 1'b1;
      end
      default: begin
        Idle = 1'b0;
      end
    endcase
  end

`ifdef CONTROL_DBG_STATE_EN
  assign State = state;
`endif

`ifndef SYNTHESIS
  // Guard on the strobe exclusivity that the datapath relies on.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      assert ($countones({Load, Ad, Sh, Done}) <= 1)
        else $error("control: more than one datapath strobe active");
    end
  end
`endif

endmodule

// File: tb/tb_control.sv
// -----------------------------------------------------------------------------
// tb_control -- self-checking bench for the multiplier control FSM.
//
// The reference model describes an operation in terms of the multiply itself.
// It tracks whether a multiply is in progress, whether an add is still waiting
// for its shift, and whether the last shift has happened. Every cycle, the DUT
// outputs are compared with this model. Directed sequences are also compared
// with hand-written strobe tables.
// -----------------------------------------------------------------------------
module tb_control;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic St  = 1'b0;
  logic M   = 1'b0;
  logic K   = 1'b0;
  logic Load, Ad, Sh, Done, Idle;
`ifdef CONTROL_DBG_STATE_EN
  logic [1:0] state_dbg;
`endif

  control dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .St   (St),
    .M    (M),
    .K    (K),
    .Load (Load),
    .Ad   (Ad),
    .Sh   (Sh),
    .Done (Done),
    .Idle (Idle)
`ifdef CONTROL_DBG_STATE_EN
    ,
    .State(state_dbg)
`endif
  );

  always #5 Clk = ~Clk;

  // Strobe vector layout: {Load, Ad, Sh, Done, Idle}
  localparam logic [4:0] V_LOAD = 5'b10001;  // Load together with Idle
  localparam logic [4:0] V_AD   = 5'b01000;
  localparam logic [4:0] V_SH   = 5'b00100;
  localparam logic [4:0] V_DONE = 5'b00010;
  localparam logic [4:0] V_IDLE = 5'b00001;

  int n_cmp = 0;
  int n_mis = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model of the multiply sequence.
  // ---------------------------------------------------------------------------
  bit busy;       // a multiply has been loaded and is not finished
  bit owe_shift;  // an add was done and its shift has not happened yet
  bit finishing;  // the final shift has happened, so report done now

  logic [4:0] last_obs;
  bit         prev_done;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] model_out(input bit st, input bit m);
    if (finishing)      return V_DONE;
    else if (!busy)     return st ? V_LOAD : V_IDLE;
    else if (owe_shift) return V_SH;
    else                return m ? V_AD : V_SH;
  endfunction

  task automatic model_advance(input bit rst, input bit st, input bit m, input bit k);
    if (rst) begin
      busy = 0; owe_shift = 0; finishing = 0;
    end else if (finishing) begin
      finishing = 0; busy = 0;
    end else if (!busy) begin
      busy = st;
    end else if (owe_shift) begin
      owe_shift = 0;
      if (k) finishing = 1;
    end else if (m) begin
      owe_shift = 1;
    end else if (k) begin
      finishing = 1;
    end
  endtask

  // Runs one clock cycle. Inputs change after the falling edge, outputs are
  // sampled 1 ns later, and the model advances at the rising edge.
  task automatic step(input bit rst, input bit st, input bit m, input bit k);
    logic [4:0] exp;
    @(negedge Clk);
    Rst = rst; St = st; M = m; K = k;
    #1;
    last_obs = {Load, Ad, Sh, Done, Idle};
    if (!rst) begin
      exp = model_out(st, m);
      check("model", last_obs, exp);
      check("exclusive", 5'($countones(last_obs[4:1]) <= 1), 5'd1);
      check("done_twice", 5'(prev_done & Done), 5'd0);
    end
    prev_done = rst ? 1'b0 : Done;
    @(posedge Clk);
    model_advance(rst, st, m, k);
  endtask

  task automatic dstep(input string tag, input bit rst, input bit st, input bit m,
                       input bit k, input logic [4:0] exp);
    step(rst, st, m, k);
    check(tag, last_obs, exp);
  endtask

  initial begin
    busy = 0; owe_shift = 0; finishing = 0; prev_done = 0;

    // Reset held two cycles with every input high.
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    dstep("reset_idle", 0, 0, 1, 1, V_IDLE);
    dstep("reset_load", 0, 1, 0, 0, V_LOAD);
    dstep("reset_sh",   0, 0, 0, 1, V_SH);
    dstep("reset_done", 0, 0, 0, 0, V_DONE);

    // Single-bit operation.
    dstep("one_idle", 0, 0, 0, 0, V_IDLE);
    dstep("one_load", 0, 1, 0, 0, V_LOAD);
    dstep("one_sh",   0, 0, 0, 1, V_SH);
    dstep("one_done", 0, 0, 0, 0, V_DONE);
    dstep("one_after",0, 0, 0, 0, V_IDLE);

    // Multiplier 1011, LSB first, with K high on the 4th bit.
    dstep("m1011_load", 0, 1, 0, 0, V_LOAD);
    dstep("m1011_ad0",  0, 0, 1, 0, V_AD);
    dstep("m1011_sh0",  0, 0, 1, 0, V_SH);
    dstep("m1011_ad1",  0, 0, 1, 0, V_AD);
    dstep("m1011_sh1",  0, 0, 1, 0, V_SH);
    dstep("m1011_sh2",  0, 0, 0, 0, V_SH);
    dstep("m1011_ad3",  0, 0, 1, 1, V_AD);
    dstep("m1011_sh3",  0, 0, 1, 1, V_SH);
    dstep("m1011_done", 0, 0, 0, 0, V_DONE);
    dstep("m1011_idle", 0, 0, 0, 0, V_IDLE);

    // St held high: restart after done, and St is ignored while busy.
    dstep("held_load",   0, 1, 1, 0, V_LOAD);
    dstep("held_ad",     0, 1, 1, 0, V_AD);
    dstep("held_sh",     0, 1, 0, 1, V_SH);
    dstep("held_done",   0, 1, 0, 0, V_DONE);
    dstep("held_reload", 0, 1, 0, 0, V_LOAD);
    dstep("held_sh2",    0, 1, 0, 0, V_SH);
    dstep("held_sh3",    0, 1, 0, 1, V_SH);
    dstep("held_done2",  0, 0, 0, 0, V_DONE);
    dstep("held_idle",   0, 0, 0, 0, V_IDLE);

    // Reset asserted while in the shift-after-add state.
    dstep("rs2_load", 0, 1, 0, 0, V_LOAD);
    dstep("rs2_ad",   0, 0, 1, 0, V_AD);
    step(1, 0, 0, 1);
    dstep("rs2_idle0", 0, 0, 0, 1, V_IDLE);
    dstep("rs2_idle1", 0, 0, 1, 1, V_IDLE);

    // Random traffic, with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      bit r, s, m, k;
      r = ($urandom_range(63) == 0);
      s = ($urandom_range(3) == 0);
      m = 1'($urandom);
      k = ($urandom_range(4) == 0);
      step(r, s, m, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
